cpu_run_ctrl: RTL
=================

Name: cpu_run_ctrl

Overview:
Sequencer that owns the cpu external memory ports and its enable. It streams a program image from a valid/ready source into data memory (port 2) and then instruction memory (port 1), and holds the core's enable high until the STOP instruction or a timeout. It then reads back a window of data memory over a valid/ready dump interface. It replaces hand-sequenced bench loading and gives a synthesizable boot/run/readback path.

Parameters:
IMEM_WORDS, 512, 64-bit words written to instruction memory.
DMEM_WORDS, 1024, 64-bit words written to data memory.
DUMP_WORDS, 47, data memory words read back after the run (word 0 up).
STOP_OPCODE, 7'b1111110, opcode field (instr[6:0]) that ends the run.
MAX_CYCLES, 100000, run-cycle timeout.

Ports:
clk  in  1  clock
arst_n  in  1  async reset, active low
start  in  1  one-cycle pulse; starts a session from IDLE
in_valid  in  1  image word valid
in_data  in  64  image word; data memory words first, then instruction memory words
in_ready  out  1  controller accepts in_data this cycle
addr_ext  out  64  imem byte address
wen_ext  out  1  imem write enable
ren_ext  out  1  imem read enable (always 0)
wdata_ext  out  64  imem write data
addr_ext_2  out  64  dmem byte address
wen_ext_2  out  1  dmem write enable
ren_ext_2  out  1  dmem read enable
wdata_ext_2  out  64  dmem write data
rdata_ext_2  in  64  dmem read data, valid the cycle after ren_ext_2
instruction  in  32  core's current instruction
enable  out  1  core enable
dump_valid  out  1  dump word valid
dump_data  out  64  dump word
dump_ready  in  1  dump consumer ready
test_id  out  4  instruction[31:28], latched at STOP
run_cycles  out  32  cycles spent in RUN
timeout  out  1  run ended by MAX_CYCLES, not STOP
done  out  1  session complete

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- IDLE: in_ready=0, enable=0. A start pulse goes to LOAD_D with word counter 0 and clears run_cycles, timeout, test_id and done. Start is ignored in every other state.
- LOAD_D: in_ready=1.
  - On a transfer (in_valid & in_ready), drive wen_ext_2=1, wdata_ext_2=in_data and addr_ext_2=cnt<<3 in the same cycle, then increment cnt.
  - If in_valid=0, no write occurs and the write enables are 0.
  - After word DMEM_WORDS-1, clear cnt and go to LOAD_I.
- LOAD_I: same as LOAD_D, on the imem port. After word IMEM_WORDS-1, go to SETTLE.
- Address/data outputs: outside a write they are 0.
- SETTLE: one cycle; in_ready=0; go to RUN.
- RUN:
  - enable=1. run_cycles increments every RUN cycle and saturates at 2^32-1.
  - If instruction[6:0]==STOP_OPCODE: latch test_id, deassert enable the next cycle and go to DUMP.
  - Otherwise, if run_cycles==MAX_CYCLES-1: set timeout=1 and go to DUMP.
  - STOP and timeout in the same cycle: STOP wins and timeout stays 0.
- DUMP: one-entry buffer.
  - Issue ren_ext_2=1 with addr_ext_2=rcnt<<3.
  - Next cycle, capture rdata_ext_2 into dump_data and set dump_valid=1.
  - dump_data is held stable until dump_valid & dump_ready; no new read is issued while the buffer is full.
  - After word DUMP_WORDS-1 is accepted, go to DONE.
  - DUMP_WORDS=0: go straight to DONE.
- DONE: done=1 and all strobes 0. Outputs hold until the next start pulse, which begins a new session.
- Async reset mid-session: returns to IDLE at once and drops enable/wen in the same instant. Memory contents are not cleared.
- Never asserted together: wen_ext and wen_ext_2; enable and any external strobe.

Test Plan:
1. Reset, then stream 1024 dmem and 512 imem words with in_valid always 1 -> 1536 contiguous writes with the last dmem address 0x1FF8 and the last imem address 0xFF8. enable rises 2 cycles after the final imem write.
2. Toggle in_valid with a random 50% duty during load -> exactly one write per handshake; addresses contiguous with no gaps; wen is 0 on idle cycles.
3. Program reaches the STOP word 0x4000007E -> test_id=4, timeout=0, enable falls, run_cycles matches the bench counter, and the 47 dump words equal the dmem contents (word 35 = 0x258).
4. Hold dump_ready low for 5 cycles mid-dump -> dump_data stable, no extra ren_ext_2, no word lost or duplicated.
5. Program loops forever with MAX_CYCLES=200 -> timeout=1, run_cycles=200, dump still runs and done=1.
6. Assert arst_n low during RUN and also during LOAD_I -> enable=0 and in_ready=0 immediately; a new start reloads from address 0.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Boot/run/readback sequencer for the cpu: streams a program image into dmem then imem,
// runs the core until STOP or timeout, then drains a window of dmem over a valid/ready port.
module cpu_run_ctrl #(
  parameter int unsigned IMEM_WORDS  = 512,
  parameter int unsigned DMEM_WORDS  = 1024,
  parameter int unsigned DUMP_WORDS  = 47,
  parameter logic [6:0]  STOP_OPCODE = 7'b1111110,
  parameter int unsigned MAX_CYCLES  = 100000
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        in_ready,
  output logic [63:0] addr_ext,
  output logic        wen_ext,
  output logic        ren_ext,
  output logic [63:0] wdata_ext,
  output logic [63:0] addr_ext_2,
  output logic        wen_ext_2,
  output logic        ren_ext_2,
  output logic [63:0] wdata_ext_2,
  input  logic [63:0] rdata_ext_2,
  input  logic [31:0] instruction,
  output logic        enable,
  output logic        dump_valid,
  output logic [63:0] dump_data,
  input  logic        dump_ready,
  output logic [3:0]  test_id,
  output logic [31:0] run_cycles,
  output logic        timeout,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_D = 3'd1,
    S_LOAD_I = 3'd2,
    S_SETTLE = 3'd3,
    S_RUN    = 3'd4,
    S_DUMP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        rd_pend_q, rd_pend_d;
  logic        dump_valid_q, dump_valid_d;
  logic [63:0] dump_data_q, dump_data_d;
  logic [31:0] run_cycles_q, run_cycles_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  test_id_q, test_id_d;
  logic        done_q, done_d;
  state_t      run_exit_s;
  logic        unused_s;

  assign unused_s   = ^instruction[27:7];
  assign run_exit_s = (DUMP_WORDS == 32'd0) ? S_DONE : S_DUMP;

  // State and counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      rcnt_q       <= 32'd0;
      rd_pend_q    <= 1'b0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= 64'd0;
      run_cycles_q <= 32'd0;
      timeout_q    <= 1'b0;
      test_id_q    <= 4'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      rd_pend_q    <= rd_pend_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      run_cycles_q <= run_cycles_d;
      timeout_q    <= timeout_d;
      test_id_q    <= test_id_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic and memory/core strobes
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    rd_pend_d    = rd_pend_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    run_cycles_d = run_cycles_q;
    timeout_d    = timeout_q;
    test_id_d    = test_id_q;
    done_d       = done_q;
    in_ready     = 1'b0;
    wen_ext      = 1'b0;
    addr_ext     = 64'd0;
    wdata_ext    = 64'd0;
    wen_ext_2    = 1'b0;
    addr_ext_2   = 64'd0;
    wdata_ext_2  = 64'd0;
    ren_ext_2    = 1'b0;
    enable       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD_D;
          cnt_d        = 32'd0;
          rcnt_d       = 32'd0;
          rd_pend_d    = 1'b0;
          dump_valid_d = 1'b0;
          dump_data_d  = 64'd0;
          run_cycles_d = 32'd0;
          timeout_d    = 1'b0;
          test_id_d    = 4'd0;
          done_d       = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD_D: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wen_ext_2   = 1'b1;
          wdata_ext_2 = in_data;
          addr_ext_2  = {29'd0, cnt_q, 3'b000};
          if (cnt_q == DMEM_WORDS - 32'd1) begin
            cnt_d   = 32'd0;
            state_d = S_LOAD_I;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_LOAD_I: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wen_ext   = 1'b1;
          wdata_ext = in_data;
          addr_ext  = {29'd0, cnt_q, 3'b000};
          if (cnt_q == IMEM_WORDS - 32'd1) begin
            cnt_d   = 32'd0;
            state_d = S_SETTLE;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_SETTLE: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        enable = 1'b1;
        if (run_cycles_q != 32'hFFFF_FFFF) begin
          run_cycles_d = run_cycles_q + 32'd1;
        end else begin
          run_cycles_d = run_cycles_q;
        end
        // STOP has priority over a coincident timeout
        if (instruction[6:0] == STOP_OPCODE) begin
          test_id_d = instruction[31:28];
          state_d   = run_exit_s;
          done_d    = (DUMP_WORDS == 32'd0);
        end else if (run_cycles_q == MAX_CYCLES - 32'd1) begin
          timeout_d = 1'b1;
          state_d   = run_exit_s;
          done_d    = (DUMP_WORDS == 32'd0);
        end else begin
          state_d = S_RUN;
        end
      end
      S_DUMP: begin
        if (dump_valid_q) begin
          if (dump_ready) begin
            dump_valid_d = 1'b0;
            if (rcnt_q == DUMP_WORDS) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DUMP;
            end
          end else begin
            dump_valid_d = 1'b1;
          end
        end else if (rd_pend_q) begin
          dump_valid_d = 1'b1;
          dump_data_d  = rdata_ext_2;
          rd_pend_d    = 1'b0;
        end else begin
          ren_ext_2  = 1'b1;
          addr_ext_2 = {29'd0, rcnt_q, 3'b000};
          rcnt_d     = rcnt_q + 32'd1;
          rd_pend_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign ren_ext    = 1'b0;
  assign dump_valid = dump_valid_q;
  assign dump_data  = dump_data_q;
  assign test_id    = test_id_q;
  assign run_cycles = run_cycles_q;
  assign timeout    = timeout_q;
  assign done       = done_q;

endmodule
